keypad_code_entry: RTL and testbench
====================================

# keypad_code_entry

- Parametrised successor to the one-hot keypad encoder.
- Converts the 16-bit one-hot keypad vector into digit and command events, and assembles a DIGITS-long BCD code for the display path.
- On ENTER, compares the assembled code against a supplied secret and tracks failed attempts.
- Optionally locks the keypad for a fixed time once the attempt limit is reached.

## Interface
- DIGITS, 4, code length in BCD digits (1..8)
- MAX_TRIES, 5, failed attempts that trigger wrap (or lockout)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- onehot  in  16  raw keypad vector, one bit per key
- code  in  4*DIGITS  secret code, BCD, most significant digit in top nibble
- digits  out  4*DIGITS  entered digits for display, newest in low nibble
- count  out  4  number of digits entered (0..DIGITS)
- key_valid  out  1  one-cycle pulse per accepted key event
- key_bin  out  4  code of the last accepted key (digits 0-9, CLEAR=4'hA, ENTER=4'hB)
- unlock  out  1  one-cycle pulse: correct code entered
- fail  out  1  one-cycle pulse: wrong code entered
- tries_out  out  8  failed-attempt count
- locked  out  1  high during lockout

## Operation
- Key map (onehot → key):
  - 0008→0, 0080→1, 0040→2, 0020→3, 0800→4, 0400→5, 0200→6, 8000→7, 4000→8, 2000→9
  - 0001→CLEAR, 0004→ENTER
  - Every other pattern, including multi-bit and zero, is no key.
- `onehot_q` registers `onehot` every cycle in every state.
- Key event: `onehot` maps to a key and `onehot != onehot_q`.
  - A held key yields exactly one event.
  - Release then re-press yields a new event.
  - A direct change from key A to key B yields an event for B.
- State ENTRY:
  - Digit with count<DIGITS: `digits <= {digits[4*DIGITS-5:0], d}`, count+1.
  - Digit with count==DIGITS: dropped; key_valid still pulses.
  - CLEAR: digits=0, count=0.
  - ENTER with count<DIGITS: no action besides key_valid.
  - ENTER with count==DIGITS and digits==code: unlock pulse, tries_out=0.
  - ENTER with count==DIGITS and mismatch: fail pulse, tries_out+1 (see Configuration).
  - Both compare outcomes clear digits and count.
- State LOCKED (macro only):
  - Key events are ignored; no key_valid pulses.
  - Lock counter counts LOCK_CYCLES cycles, then: tries_out=0, digits=0, count=0, locked=0, state returns to ENTRY.
- Reset (any time, including mid-lock):
  - All outputs 0, `onehot_q` 0, lock counter 0, state ENTRY.
  - A key already held as reset releases produces one event on the first edge after reset.

## Timing
- Key event detected at rising edge N; digits, count, tries_out and state update at edge N.
- key_valid, key_bin, unlock and fail are registered and visible for the cycle after edge N, one cycle wide.
- key_bin holds its value between events.
- Lockout entry:
  - locked rises at the same edge as the MAX_TRIES-th fail update, and fail pulses alongside.
  - locked stays high for exactly LOCK_CYCLES cycles.
  - The first key accepted after lockout is at the edge after locked falls.
- Comparison uses the full 4*DIGITS bits; `code` must be stable from the ENTER edge.

## Configuration
- Macro: `KEYPAD_LOCKOUT_EN`.
- Defined:
  - The fail that brings tries_out to MAX_TRIES enters LOCKED.
  - tries_out reads MAX_TRIES during lockout, then clears.
- Undefined:
  - No LOCKED state; locked is tied to 0 and LOCK_CYCLES is unused.
  - On a fail with tries_out<MAX_TRIES, tries_out+1.
  - Otherwise tries_out wraps to 0, giving 0..MAX_TRIES then 0.

## Test plan
- Reset, then press 1,2,3,4 (0080,0040,0020,0800, each held 3 cycles then 0000) → digits=16'h1234, count=4, exactly four key_valid pulses.
- code=16'h1234, enter 1234 then ENTER (0004) → one unlock pulse, tries_out=0, digits=0, count=0.
- Enter 9999, ENTER with code=16'h1234 → one fail pulse, tries_out=1. Then press a fifth digit after 4 digits → digits unchanged, key_valid pulses.
- Enter 12, CLEAR (0001) → digits=0, count=0. Multi-bit pattern 0088 → no key_valid. Direct change 0080→0040 without release → event for 2.
- With `KEYPAD_LOCKOUT_EN`, MAX_TRIES=2, LOCK_CYCLES=10, two wrong codes:
  - locked=1 for 10 cycles and keys are ignored.
  - Afterwards tries_out=0 and the next press is accepted.
  - Assert rst mid-lock → locked=0 immediately.
- Without `KEYPAD_LOCKOUT_EN`, MAX_TRIES=5, six wrong codes → tries_out sequence 1,2,3,4,5,0; locked stays 0.

Source files
------------

// File: rtl/keypad_code_entry.sv
// keypad_code_entry
// Turns the raw 16-bit one-hot keypad vector into digit / CLEAR / ENTER
// events, shifts digits into a DIGITS-long BCD code for display, and checks
// the code against i_code on ENTER while counting failed attempts.
// Optional feature macro: KEYPAD_LOCKOUT_EN
//   defined   : reaching MAX_TRIES failed attempts locks the keypad for
//               LOCK_CYCLES clock cycles, then clears the attempt count.
//   undefined : no lockout; the attempt count wraps 0..MAX_TRIES then 0,
//               and o_locked is tied low.
//
// state     | meaning
// ST_ENTRY  | accepting keys, assembling and checking the code
// ST_LOCKED | keypad ignored until the lockout timer expires (macro only)

module keypad_code_entry #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 5,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_onehot,
  input  logic [4*DIGITS-1:0]   i_code,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic [3:0]            o_count,
  output logic                  o_key_valid,
  output logic [3:0]            o_key_bin,
  output logic                  o_unlock,
  output logic                  o_fail,
  output logic [7:0]            o_tries_out,
  output logic                  o_locked
);

  localparam int         DW        = 4 * DIGITS;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] FULL      = 4'(DIGITS);
  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  // Reject parameter values the datapath cannot represent.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("keypad_code_entry: DIGITS must be 1..8");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("keypad_code_entry: LOCK_CYCLES must be >= 1");
  end

  logic [15:0]   r_onehot_q;
  logic [DW-1:0] r_digits;
  logic [3:0]    r_count;
  logic          r_key_valid;
  logic [3:0]    r_key_bin;
  logic          r_unlock;
  logic          r_fail;
  logic [7:0]    r_tries;
  logic          r_locked;

  logic          w_key_hit;
  logic [3:0]    w_key;
  logic          w_event;
  logic          w_is_digit;
  logic          w_code_match;

`ifdef KEYPAD_LOCKOUT_EN
  // Timer holds LOCK_CYCLES-1 down to 0; the exit edge is the one that sees 0.
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {
    ST_ENTRY  = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  logic [LW-1:0] r_lock_cnt;
`endif

  // Key map: exactly one recognised pattern yields a key, anything else is no key.
  always_comb begin
    w_key_hit = 1'b1;
    w_key     = 4'h0;
    case (i_onehot)
      16'h0008: w_key = 4'd0;
      16'h0080: w_key = 4'd1;
      16'h0040: w_key = 4'd2;
      16'h0020: w_key = 4'd3;
      16'h0800: w_key = 4'd4;
      16'h0400: w_key = 4'd5;
      16'h0200: w_key = 4'd6;
      16'h8000: w_key = 4'd7;
      16'h4000: w_key = 4'd8;
      16'h2000: w_key = 4'd9;
      16'h0001: w_key = KEY_CLEAR;
      16'h0004: w_key = KEY_ENTER;
      default:  w_key_hit = 1'b0;
    endcase
  end

  // An event is a valid key whose pattern differs from last cycle's sample,
  // so a held key fires once and a direct key-to-key change fires again.
  assign w_event      = w_key_hit && (i_onehot != r_onehot_q);
  assign w_is_digit   = (w_key <= 4'd9);
  assign w_code_match = (r_digits == i_code);

  // Code-entry FSM: key handling, compare, attempt tracking and lockout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_onehot_q  <= '0;
      r_digits    <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_key_bin   <= '0;
      r_unlock    <= 1'b0;
      r_fail      <= 1'b0;
      r_tries     <= '0;
      r_locked    <= 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
      r_state     <= ST_ENTRY;
      r_lock_cnt  <= '0;
`endif
    end else begin
      r_onehot_q  <= i_onehot;
      r_key_valid <= 1'b0;
      r_unlock    <= 1'b0;
      r_fail      <= 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
      if (r_state == ST_LOCKED) begin
        if (r_lock_cnt == '0) begin
          r_state  <= ST_ENTRY;
          r_locked <= 1'b0;
          r_tries  <= '0;
          r_digits <= '0;
          r_count  <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt - 1'b1;
        end
      end else
`endif
      if (w_event) begin
        r_key_valid <= 1'b1;
        r_key_bin   <= w_key;
        if (w_is_digit) begin
          // A digit beyond the code length is acknowledged but dropped.
          if (r_count < FULL) begin
            r_digits <= (r_digits << 4) | DW'(w_key);
            r_count  <= r_count + 4'd1;
          end
        end else if (w_key == KEY_CLEAR) begin
          r_digits <= '0;
          r_count  <= '0;
        end else if (r_count == FULL) begin
          // ENTER on a complete code; a partial code ENTER only acknowledges.
          r_digits <= '0;
          r_count  <= '0;
          if (w_code_match) begin
            r_unlock <= 1'b1;
            r_tries  <= '0;
          end else begin
            r_fail <= 1'b1;
`ifdef KEYPAD_LOCKOUT_EN
            r_tries <= r_tries + 8'd1;
            if (r_tries + 8'd1 >= TRY_LIMIT) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_lock_cnt <= LW'(LOCK_CYCLES - 1);
            end
`else
            r_tries <= (r_tries < TRY_LIMIT) ? r_tries + 8'd1 : 8'd0;
`endif
          end
        end
      end
    end
  end

  assign o_digits    = r_digits;
  assign o_count     = r_count;
  assign o_key_valid = r_key_valid;
  assign o_key_bin   = r_key_bin;
  assign o_unlock    = r_unlock;
  assign o_fail      = r_fail;
  assign o_tries_out = r_tries;
  assign o_locked    = r_locked;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Testbench for keypad_code_entry: directed scenarios plus randomized key
// sequences, every cycle compared against a queue-based reference model.
// Build with or without KEYPAD_LOCKOUT_EN.

module tb_keypad_code_entry;

  localparam int DIGITS      = 4;
`ifdef KEYPAD_LOCKOUT_EN
  localparam int MAX_TRIES   = 2;
`else
  localparam int MAX_TRIES   = 5;
`endif
  localparam int LOCK_CYCLES = 10;

  logic                i_clk;
  logic                i_rst;
  logic [15:0]         i_onehot;
  logic [4*DIGITS-1:0] i_code;
  logic [4*DIGITS-1:0] o_digits;
  logic [3:0]          o_count;
  logic                o_key_valid;
  logic [3:0]          o_key_bin;
  logic                o_unlock;
  logic                o_fail;
  logic [7:0]          o_tries_out;
  logic                o_locked;

  keypad_code_entry #(
    .DIGITS      (DIGITS),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_onehot    (i_onehot),
    .i_code      (i_code),
    .o_digits    (o_digits),
    .o_count     (o_count),
    .o_key_valid (o_key_valid),
    .o_key_bin   (o_key_bin),
    .o_unlock    (o_unlock),
    .o_fail      (o_fail),
    .o_tries_out (o_tries_out),
    .o_locked    (o_locked)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse tallies observed on the DUT, compared against expected totals.
  int n_kv  = 0;
  int n_unl = 0;
  int n_fl  = 0;

  logic [15:0] pat [12] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020,
                            16'h0800, 16'h0400, 16'h0200, 16'h8000,
                            16'h4000, 16'h2000, 16'h0001, 16'h0004};

  // Reference model state.
  int          m_q[$];
  int          m_tries;
  int          m_lock_left;
  logic [15:0] m_prev;
  int          e_kv, e_kb, e_unl, e_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [15:0] p);
    for (int k = 0; k < 12; k++)
      if (p == pat[k]) return k;
    return -1;
  endfunction

  function automatic longint model_digits();
    longint v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return v;
  endfunction

  function automatic bit model_match();
    int c = int'(i_code);
    for (int i = 0; i < DIGITS; i++)
      if (m_q[i] != ((c >> (4 * (DIGITS - 1 - i))) & 15)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_tries = 0; m_lock_left = 0; m_prev = '0;
    e_kv = 0; e_kb = 0; e_unl = 0; e_fail = 0;
  endtask

  task automatic model_step(input logic [15:0] x);
    int k;
    bit ev;
    k  = key_of(x);
    ev = (k >= 0) && (x != m_prev);
    m_prev = x;
    e_kv = 0; e_unl = 0; e_fail = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_tries = 0;
        m_q.delete();
      end
    end else if (ev) begin
      e_kv = 1;
      e_kb = k;
      if (k <= 9) begin
        if (m_q.size() < DIGITS) m_q.push_back(k);
      end else if (k == 10) begin
        m_q.delete();
      end else if (m_q.size() == DIGITS) begin
        if (model_match()) begin
          e_unl   = 1;
          m_tries = 0;
        end else begin
          e_fail = 1;
`ifdef KEYPAD_LOCKOUT_EN
          m_tries++;
          if (m_tries >= MAX_TRIES) m_lock_left = LOCK_CYCLES;
`else
          m_tries = (m_tries < MAX_TRIES) ? m_tries + 1 : 0;
`endif
        end
        m_q.delete();
      end
    end
  endtask

  task automatic compare_all();
    check_val("key_valid", 32'(o_key_valid), 32'(e_kv));
    check_val("key_bin",   32'(o_key_bin),   32'(e_kb));
    check_val("unlock",    32'(o_unlock),    32'(e_unl));
    check_val("fail",      32'(o_fail),      32'(e_fail));
    check_val("digits",    32'(o_digits),    32'(model_digits()));
    check_val("count",     32'(o_count),     32'(m_q.size()));
    check_val("tries_out", 32'(o_tries_out), 32'(m_tries));
    check_val("locked",    32'(o_locked),    32'(m_lock_left > 0));
  endtask

  task automatic tick(input logic [15:0] v);
    i_onehot = v;
    @(posedge i_clk);
    model_step(v);
    #1;
    compare_all();
    n_kv  += int'(o_key_valid);
    n_unl += int'(o_unlock);
    n_fl  += int'(o_fail);
  endtask

  task automatic press(input int k, input int hold);
    repeat (hold) tick(pat[k]);
    tick(16'h0000);
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    press(d0, 3); press(d1, 3); press(d2, 3); press(d3, 3);
    press(11, 3);
  endtask

  // Reset asserted over one edge with a given pattern on the keypad.
  task automatic do_reset(input logic [15:0] held);
    i_onehot = held;
    i_rst    = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    compare_all();
    i_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int base_kv, base_unl, base_fl, n_lock, guard;
    int seq[6] = '{1, 2, 3, 4, 5, 0};

    i_rst    = 1'b1;
    i_onehot = '0;
    i_code   = 16'h1234;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    compare_all();
    i_rst = 1'b0;

    // Digits 1,2,3,4 fill the code.
    base_kv = n_kv;
    press(1, 3); press(2, 3); press(3, 3); press(4, 3);
    check_val("digits_1234", 32'(o_digits), 32'h1234);
    check_val("count_4",     32'(o_count),  32'd4);
    check_val("kv_pulses_4", 32'(n_kv - base_kv), 32'd4);

    // Correct code.
    base_unl = n_unl;
    press(11, 3);
    check_val("unlock_once", 32'(n_unl - base_unl), 32'd1);
    check_val("unlock_tries", 32'(o_tries_out), 32'd0);
    check_val("unlock_count", 32'(o_count), 32'd0);

    // Wrong code, then a fifth digit on a full code.
    base_fl = n_fl;
    enter_code(9, 9, 9, 9);
    check_val("fail_once",  32'(n_fl - base_fl), 32'd1);
    check_val("fail_tries", 32'(o_tries_out), 32'd1);
    press(1, 3); press(2, 3); press(3, 3); press(4, 3);
    base_kv = n_kv;
    press(5, 3);
    check_val("fifth_digit_kv",     32'(n_kv - base_kv), 32'd1);
    check_val("fifth_digit_digits", 32'(o_digits), 32'h1234);
    press(10, 2);

    // CLEAR, multi-bit pattern, direct key change.
    press(1, 2); press(2, 2); press(10, 2);
    check_val("clear_digits", 32'(o_digits), 32'd0);
    check_val("clear_count",  32'(o_count),  32'd0);
    base_kv = n_kv;
    repeat (3) tick(16'h0088);
    tick(16'h0000);
    check_val("multibit_no_kv", 32'(n_kv - base_kv), 32'd0);
    tick(16'h0080); tick(16'h0080); tick(16'h0040);
    check_val("direct_change_kv",  32'(o_key_valid), 32'd1);
    check_val("direct_change_bin", 32'(o_key_bin),   32'd2);
    tick(16'h0040); tick(16'h0000);
    check_val("direct_change_digits", 32'(o_digits), 32'h12);
    press(10, 1);

    // Clear the attempt count with a good code.
    enter_code(1, 2, 3, 4);
    check_val("reunlock_tries", 32'(o_tries_out), 32'd0);

`ifdef KEYPAD_LOCKOUT_EN
    enter_code(9, 9, 9, 9);
    press(9, 2); press(9, 2); press(9, 2); press(9, 2);
    tick(pat[11]);
    n_lock = int'(o_locked);
    check_val("lock_tries_max", 32'(o_tries_out), 32'(MAX_TRIES));
    base_kv = n_kv;
    guard = 0;
    while (o_locked && guard < 100) begin
      tick((guard % 2 == 1) ? 16'h0000 : pat[guard % 4]);
      if (o_locked) n_lock++;
      guard++;
    end
    check_val("lock_cycles",  32'(n_lock), 32'(LOCK_CYCLES));
    check_val("lock_no_kv",   32'(n_kv - base_kv), 32'd0);
    check_val("lock_tries_0", 32'(o_tries_out), 32'd0);
    tick(pat[7]);
    check_val("post_lock_kv",  32'(o_key_valid), 32'd1);
    check_val("post_lock_bin", 32'(o_key_bin),   32'd7);
    tick(16'h0000);
    press(10, 1);

    // Reset in the middle of a lockout.
    enter_code(9, 9, 9, 9);
    enter_code(9, 9, 9, 9);
    check_val("midlock_locked", 32'(o_locked), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check_val("rst_locked_async", 32'(o_locked),    32'd0);
    check_val("rst_tries_async",  32'(o_tries_out), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    compare_all();
    i_rst = 1'b0;
`else
    for (int j = 0; j < 6; j++) begin
      enter_code(9, 9, 9, 9);
      check_val("wrap_tries", 32'(o_tries_out), 32'(seq[j]));
      check_val("wrap_locked", 32'(o_locked), 32'd0);
    end
`endif

    // Key held while reset releases yields one event.
    do_reset(pat[5]);
    tick(pat[5]);
    check_val("held_reset_kv",  32'(o_key_valid), 32'd1);
    check_val("held_reset_bin", 32'(o_key_bin),   32'd5);
    tick(pat[5]);
    check_val("held_reset_once", 32'(o_key_valid), 32'd0);
    tick(16'h0000);

    // Randomized key sequences against the model.
    for (int it = 0; it < 400; it++) begin
      int r, k, hold;
      logic [15:0] p;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        i_code = '0;
        for (int i = 0; i < DIGITS; i++)
          i_code = (i_code << 4) | 16'($urandom_range(1, 2));
      end
      r = int'($urandom_range(0, 99));
      if (r < 55)      p = pat[$urandom_range(1, 2)];
      else if (r < 72) p = pat[11];
      else if (r < 77) p = pat[10];
      else if (r < 87) p = pat[$urandom_range(0, 9)];
      else if (r < 92) p = 16'($urandom);
      else             p = 16'h0000;
      k = key_of(p);
      if (k < 0 && r < 92) p = p | 16'h0101;
      hold = int'($urandom_range(1, 3));
      repeat (hold) tick(p);
      if ($urandom_range(0, 9) < 7) tick(16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
